frame_to_sdram_writer: RTL and testbench

FRAME_TO_SDRAM_WRITER -- requirements
Module: frame_to_sdram_writer

---
 rtl/frame_to_sdram_writer.sv | 113 +++++++++++
 tb/tb_frame_to_sdram_writer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_to_sdram_writer.sv
// rtl/frame_to_sdram_writer.sv - packs pixel byte pairs into 16-bit words and writes a frame to SDRAM
module frame_to_sdram_writer #(
    parameter int LINES      = 1024,
    parameter int LINE_WORDS = 512
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [5:0]  iFRAME_ID,
    input  logic        iSTART,
    input  logic        iABORT,
    input  logic [7:0]  iPIX_DATA,
    input  logic        iPIX_VALID,
    output logic        oPIX_READY,
    output logic        oWR_EN,
    output logic [24:0] oWR_ADDR,
    output logic [15:0] oWR_DATA,
    input  logic        iWAIT_REQUEST,
    output logic        oBUSY,
    output logic        oDONE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL_U = 3'd1;
    localparam logic [2:0] S_FILL_L = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [9:0] LAST_LINE = 10'(LINES - 1);
    localparam logic [8:0] LAST_WORD = 9'(LINE_WORDS - 1);

    logic [2:0]  state_q, state_d;
    logic [5:0]  frame_q, frame_d;
    logic [9:0]  line_q,  line_d;
    logic [8:0]  word_q,  word_d;
    logic [15:0] data_q,  data_d;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        line_d  = line_q;
        word_d  = word_q;
        data_d  = data_q;
        // Abort wins over everything else, including a byte or write handshake this cycle.
        if (iABORT && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iSTART) begin
                        frame_d = iFRAME_ID;
                        line_d  = '0;
                        word_d  = '0;
                        state_d = S_FILL_U;
                    end
                end
                S_FILL_U: begin
                    if (iPIX_VALID) begin
                        data_d[15:8] = iPIX_DATA;
                        state_d      = S_FILL_L;
                    end
                end
                S_FILL_L: begin
                    if (iPIX_VALID) begin
                        data_d[7:0] = iPIX_DATA;
                        state_d     = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!iWAIT_REQUEST) begin
                        state_d = S_FILL_U;
                        if (word_q == LAST_WORD) begin
                            word_d = '0;
                            // The final line leaves line at LINES-1 so counters never wrap.
                            if (line_q == LAST_LINE) begin
                                state_d = S_DONE;
                            end else begin
                                line_d = line_q + 10'd1;
                            end
                        end else begin
                            word_d = word_q + 9'd1;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= S_IDLE;
            frame_q <= '0;
            line_q  <= '0;
            word_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            line_q  <= line_d;
            word_q  <= word_d;
            data_q  <= data_d;
        end
    end

    assign oPIX_READY = (state_q == S_FILL_U) || (state_q == S_FILL_L);
    assign oWR_EN     = (state_q == S_WRITE);
    assign oWR_ADDR   = {frame_q, line_q, word_q};
    assign oWR_DATA   = data_q;
    assign oBUSY      = (state_q == S_FILL_U) || (state_q == S_FILL_L) || (state_q == S_WRITE);
    assign oDONE      = (state_q == S_DONE);

endmodule

// File: tb/tb_frame_to_sdram_writer.sv
// tb/tb_frame_to_sdram_writer.sv - directed self-checking bench for frame_to_sdram_writer
module tb_frame_to_sdram_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  frame_id;
    logic        start;
    logic        abort_r;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        wr_en;
    logic [24:0] wr_addr;
    logic [15:0] wr_data;
    logic        wait_req;
    logic        busy;
    logic        done;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    logic [24:0] acc_addr[$];
    logic [15:0] acc_data[$];
    int          acc_cyc[$];

    frame_to_sdram_writer #(.LINES(2), .LINE_WORDS(2)) dut (
        .iCLK(clk), .iRST(rst), .iFRAME_ID(frame_id), .iSTART(start), .iABORT(abort_r),
        .iPIX_DATA(pix_data), .iPIX_VALID(pix_valid), .oPIX_READY(pix_ready),
        .oWR_EN(wr_en), .oWR_ADDR(wr_addr), .oWR_DATA(wr_data),
        .iWAIT_REQUEST(wait_req), .oBUSY(busy), .oDONE(done)
    );

    always #5 clk = ~clk;

    // Records every accepted write and every DONE pulse seen at a rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (wr_en && !wait_req) begin
                acc_addr.push_back(wr_addr);
                acc_data.push_back(wr_data);
                acc_cyc.push_back(cyc);
            end
            if (done) done_cnt = done_cnt + 1;
        end
    end

    function automatic logic [24:0] ea(input logic [5:0] f, input logic [9:0] l, input logic [8:0] w);
        return {f, l, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        acc_addr.delete();
        acc_data.delete();
        acc_cyc.delete();
        done_cnt = 0;
    endtask

    // Leaves iPIX_VALID high so consecutive calls stream at full rate.
    task automatic feed(input logic [7:0] b);
        int k;
        pix_data  = b;
        pix_valid = 1'b1;
        k = 0;
        while (!pix_ready && k < 100) begin
            tick();
            k++;
        end
        if (!pix_ready) begin
            vectors++; errors++;
            $display("FAIL feed_timeout byte=%h never accepted", b);
        end else begin
            tick();
        end
    endtask

    task automatic wait_accepts(input int n);
        int k;
        k = 0;
        while (acc_addr.size() < n && k < 200) begin
            tick();
            k++;
        end
        if (acc_addr.size() < n) begin
            vectors++; errors++;
            $display("FAIL accept_timeout got %0d accepts, need %0d", acc_addr.size(), n);
        end
    endtask

    task automatic start_frame(input logic [5:0] id);
        frame_id = id;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic pulse_abort();
        abort_r = 1'b1;
        tick();
        abort_r = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort_r = 1'b1; frame_id = 6'h3f;
        pix_valid = 1'b1; pix_data = 8'hff; wait_req = 1'b0;
        tick(); tick(); tick();
        vectors++;
        if ({pix_ready, wr_en, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {pix_ready, wr_en, busy, done});
        end
        vectors++;
        if (wr_addr !== 25'd0 || wr_data !== 16'd0) begin
            errors++; $display("FAIL reset_addr_data got %h/%h exp 0/0", wr_addr, wr_data);
        end
        rst = 1'b0; start = 1'b0; abort_r = 1'b0; pix_valid = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        logic [15:0] exp_d [4];
        logic [24:0] exp_a [4];
        exp_d = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        exp_a = '{ea(6'd5, 10'd0, 9'd0), ea(6'd5, 10'd0, 9'd1), ea(6'd5, 10'd1, 9'd0), ea(6'd5, 10'd1, 9'd1)};
        clear_log();
        start_frame(6'd5);
        for (int i = 1; i <= 8; i++) feed(8'(i));
        pix_valid = 1'b0;
        wait_accepts(4);
        tick(); tick(); tick();
        vectors++;
        if (acc_addr.size() !== 4) begin
            errors++; $display("FAIL basic_count got %0d exp 4", acc_addr.size());
        end
        for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
            vectors++;
            if (acc_addr[i] !== exp_a[i] || acc_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL basic_word%0d got %h/%h exp %h/%h", i, acc_addr[i], acc_data[i], exp_a[i], exp_d[i]);
            end
        end
        vectors++;
        if (acc_cyc.size() >= 2 && acc_cyc[1] - acc_cyc[0] !== 3) begin
            errors++; $display("FAIL basic_throughput got %0d cycles exp 3", acc_cyc[1] - acc_cyc[0]);
        end
        vectors++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_done got done=%0d busy=%b exp 1/0", done_cnt, busy);
        end
    endtask

    task automatic test_stall();
        clear_log();
        wait_req = 1'b1;
        start_frame(6'd2);
        feed(8'hAA); feed(8'hBB);
        pix_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (wr_en !== 1'b1 || pix_ready !== 1'b0 || wr_addr !== ea(6'd2, 10'd0, 9'd0) || wr_data !== 16'hAABB) begin
                errors++;
                $display("FAIL stall_hold%0d got en=%b rdy=%b %h/%h exp 1/0 %h/aabb", i, wr_en, pix_ready, wr_addr, wr_data, ea(6'd2, 10'd0, 9'd0));
            end
            tick();
        end
        vectors++;
        if (acc_addr.size() !== 0) begin
            errors++; $display("FAIL stall_no_accept got %0d exp 0", acc_addr.size());
        end
        wait_req = 1'b0;
        tick();
        vectors++;
        if (acc_addr.size() !== 1 || wr_en !== 1'b0) begin
            errors++; $display("FAIL stall_one_accept got %0d en=%b exp 1/0", acc_addr.size(), wr_en);
        end
        wait_req = 1'b1;
        feed(8'hCC); feed(8'hDD);
        pix_valid = 1'b0;
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== ea(6'd2, 10'd0, 9'd1)) begin
            errors++; $display("FAIL stall_word1 got en=%b %h exp 1 %h", wr_en, wr_addr, ea(6'd2, 10'd0, 9'd1));
        end
        pulse_abort();
        vectors++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || acc_addr.size() !== 1) begin
            errors++; $display("FAIL stall_abort got en=%b busy=%b acc=%0d exp 0/0/1", wr_en, busy, acc_addr.size());
        end
        wait_req = 1'b0;
    endtask

    task automatic test_valid_gap();
        clear_log();
        start_frame(6'd3);
        feed(8'h11);
        pix_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (wr_en !== 1'b0 || pix_ready !== 1'b1) begin
                errors++; $display("FAIL gap_wait%0d got en=%b rdy=%b exp 0/1", i, wr_en, pix_ready);
            end
            tick();
        end
        feed(8'h22);
        pix_valid = 1'b0;
        wait_accepts(1);
        vectors++;
        if (acc_data.size() < 1 || acc_data[0] !== 16'h1122 || acc_addr[0] !== ea(6'd3, 10'd0, 9'd0)) begin
            errors++; $display("FAIL gap_pair got %0d accepts first=%h exp 1122", acc_data.size(), acc_data.size() ? acc_data[0] : 16'hx);
        end
        pulse_abort();
    endtask

    task automatic test_start_while_busy();
        clear_log();
        start_frame(6'd4);
        feed(8'h44);
        pix_valid = 1'b0;
        start_frame(6'd9);
        vectors++;
        if (pix_ready !== 1'b1 || wr_addr !== ea(6'd4, 10'd0, 9'd0)) begin
            errors++; $display("FAIL busy_start got rdy=%b %h exp 1 %h", pix_ready, wr_addr, ea(6'd4, 10'd0, 9'd0));
        end
        feed(8'h55);
        pix_valid = 1'b0;
        wait_accepts(1);
        feed(8'h66); feed(8'h77);
        pix_valid = 1'b0;
        wait_accepts(2);
        vectors++;
        if (acc_addr.size() < 2 || acc_data[0] !== 16'h4455 || acc_addr[1] !== ea(6'd4, 10'd0, 9'd1) || acc_data[1] !== 16'h6677) begin
            errors++; $display("FAIL busy_words got %0d accepts exp 2 at frame 4 data 4455/6677", acc_addr.size());
        end
        pulse_abort();
    endtask

    task automatic test_abort();
        clear_log();
        start_frame(6'd7);
        for (int i = 1; i <= 6; i++) feed(8'(i));
        pix_valid = 1'b0;
        wait_accepts(3);
        pulse_abort();
        vectors++;
        if ({busy, pix_ready, wr_en} !== 3'b000) begin
            errors++; $display("FAIL abort_idle got %b exp 000", {busy, pix_ready, wr_en});
        end
        tick(); tick(); tick();
        vectors++;
        if (done_cnt !== 0 || acc_addr.size() !== 3) begin
            errors++; $display("FAIL abort_nodone got done=%0d acc=%0d exp 0/3", done_cnt, acc_addr.size());
        end
        clear_log();
        start_frame(6'd1);
        for (int i = 0; i < 8; i++) feed(8'h10 + 8'(i));
        pix_valid = 1'b0;
        pulse_abort();
        tick(); tick(); tick();
        vectors++;
        if (acc_addr.size() !== 4 || acc_addr[0] !== 25'h080000 || acc_addr[3] !== ea(6'd1, 10'd1, 9'd1)) begin
            errors++; $display("FAIL abort_restart got acc=%0d first=%h exp 4 first=080000", acc_addr.size(), acc_addr.size() ? acc_addr[0] : 25'hx);
        end
        vectors++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_last_word got done=%0d busy=%b exp 0/0", done_cnt, busy);
        end
    endtask

    task automatic test_reset_stalled();
        clear_log();
        wait_req = 1'b1;
        start_frame(6'd6);
        feed(8'h12); feed(8'h34);
        pix_valid = 1'b0;
        vectors++;
        if (wr_en !== 1'b1) begin
            errors++; $display("FAIL rst_stall_pre got en=%b exp 1", wr_en);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({pix_ready, wr_en, busy, done} !== 4'b0000 || wr_addr !== 25'd0 || wr_data !== 16'd0) begin
            errors++; $display("FAIL rst_stall_outputs got %b %h/%h exp 0000 0/0", {pix_ready, wr_en, busy, done}, wr_addr, wr_data);
        end
        rst = 1'b0;
        wait_req = 1'b0;
        tick();
        start_frame(6'd2);
        vectors++;
        if (pix_ready !== 1'b1 || busy !== 1'b1 || wr_addr !== ea(6'd2, 10'd0, 9'd0)) begin
            errors++; $display("FAIL rst_restart got rdy=%b busy=%b %h exp 1/1 %h", pix_ready, busy, wr_addr, ea(6'd2, 10'd0, 9'd0));
        end
        pulse_abort();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_valid_gap();
        test_start_while_busy();
        test_abort();
        test_reset_stalled();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
